// File: rtl/common_pkg.sv
// Shared types for the matrix-multiply instruction path.
// Provides addr_t, op_t (MMUL_D / MMUL_ND), instruction_t, a unit mask type
// sized for the largest supported unit count, and the round-robin picker.
package common_pkg;

    localparam int unsigned ADDR_W     = 8;
    localparam int unsigned MAX_UNITS  = 8;
    localparam int unsigned UNIT_IDX_W = 3;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic {
        MMUL_D  = 1'b0,
        MMUL_ND = 1'b1
    } op_t;

    typedef struct packed {
        op_t   op;
        addr_t dest;
        addr_t src1;
        addr_t src2;
    } instruction_t;

    typedef logic [MAX_UNITS-1:0] unit_mask_t;

    typedef struct packed {
        logic                  found;
        logic [UNIT_IDX_W-1:0] idx;
    } unit_pick_t;

    // First set bit of mask scanning ptr, ptr+1, ... modulo n (n <= MAX_UNITS).
    function automatic unit_pick_t rr_pick(unit_mask_t mask, logic [UNIT_IDX_W-1:0] ptr,
                                           int unsigned n);
        unit_pick_t  p;
        int unsigned idx;
        p = '0;
        for (int unsigned k = 0; k < MAX_UNITS; k++) begin
            idx = (32'(ptr) + k) % n;
            if (k < n && !p.found && mask[idx[UNIT_IDX_W-1:0]]) begin
                p.found = 1'b1;
                p.idx   = idx[UNIT_IDX_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Generic in-order FIFO with occupancy count.
// Ports: clk, reset (sync, active-low), wr_data/wr_en (ignored when full),
//        rd_data (head, valid when !empty), rd_en (pop, ignored when empty),
//        count, full, empty. DEPTH must be a power of two so pointers wrap freely.
module inst_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter type         T     = logic [7:0],
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  T                 wr_data,
    input  logic             wr_en,
    output T                 rd_data,
    input  logic             rd_en,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/inst_issue_queue.sv
// Instruction buffer between the host front-end and NUM_UNITS mmul units.
// Queues instructions in order and issues the head to a free, ready unit chosen
// round-robin, holding it back on RAW/WAW address hazards against in-flight
// work and serialising MMUL_D behind an idle machine.
// Ports: clk, reset (sync, active-low); in_inst/in_valid/in_ready (enqueue);
//        out_inst/out_valid (one-hot target)/out_ready (issue); done (unit
//        finished); count (entries held); busy (units in flight); hazard.
// Optional: define IQ_PERF_CNT_EN to add issued_cnt and stall_cnt counters.
module inst_issue_queue
    import common_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned NUM_UNITS = 2,
    localparam int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  instruction_t         in_inst,
    input  logic                 in_valid,
    output logic                 in_ready,
    output instruction_t         out_inst,
    output logic [NUM_UNITS-1:0] out_valid,
    input  logic [NUM_UNITS-1:0] out_ready,
    input  logic [NUM_UNITS-1:0] done,
    output logic [CNT_W-1:0]     count,
    output logic [NUM_UNITS-1:0] busy,
    output logic                 hazard
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]          issued_cnt,
    output logic [31:0]          stall_cnt
`endif
);

    instruction_t                head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic                        head_valid;
    logic                        push;
    logic                        issue;
    logic                        issue_ok;
    logic                        blocked;
    addr_t                       inflight_dest [NUM_UNITS];
    logic [UNIT_IDX_W-1:0]       rr_ptr;
    logic [UNIT_IDX_W-1:0]       rr_next;
    unit_mask_t                  avail_mask;
    unit_pick_t                  pick;
    logic [NUM_UNITS-1:0]        issue_vec;
    logic [NUM_UNITS-1:0]        busy_next;

    inst_fifo #(
        .DEPTH (DEPTH),
        .T     (instruction_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_data (in_inst),
        .wr_en   (push),
        .rd_data (head),
        .rd_en   (issue),
        .count   (count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Full is judged on registered count, so a same-cycle pop never frees a slot early.
    assign in_ready   = reset && !fifo_full;
    assign push       = in_valid && in_ready;
    assign head_valid = reset && !fifo_empty;
    assign out_inst   = head;

    // Hazard check against registered in-flight state.
    always_comb begin
        blocked = 1'b0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            if (busy[u]) begin
                if (head.op == MMUL_D) begin
                    blocked = 1'b1;
                end else if (head.src1 == inflight_dest[u] ||
                             head.src2 == inflight_dest[u] ||
                             head.dest == inflight_dest[u]) begin
                    blocked = 1'b1;
                end
            end
        end
    end

    // Round-robin unit selection and issue decode.
    always_comb begin
        avail_mask                  = '0;
        avail_mask[NUM_UNITS-1:0]   = ~busy & out_ready;
        pick                        = rr_pick(avail_mask, rr_ptr, NUM_UNITS);
        issue_ok                    = head_valid && !blocked && pick.found;
        issue_vec                   = '0;
        for (int unsigned u = 0; u < NUM_UNITS; u++) begin
            issue_vec[u] = issue_ok && (pick.idx == UNIT_IDX_W'(u));
        end
        rr_next   = UNIT_IDX_W'((32'(pick.idx) + 32'd1) % NUM_UNITS);
        // Done on an idle unit falls out naturally: its busy bit is already 0.
        busy_next = (busy & ~done) | issue_vec;
    end

    assign out_valid = issue_vec;
    assign issue     = |issue_vec;
    assign hazard    = head_valid && blocked;

    // In-flight table and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy   <= '0;
            rr_ptr <= '0;
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                inflight_dest[u] <= '0;
            end
        end else begin
            busy <= busy_next;
            if (issue) rr_ptr <= rr_next;
            for (int unsigned u = 0; u < NUM_UNITS; u++) begin
                if (issue_vec[u]) inflight_dest[u] <= head.dest;
            end
        end
    end

`ifdef IQ_PERF_CNT_EN
    // Issue and hazard-stall counters, free-running modulo 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            issued_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            if (issue)  issued_cnt <= issued_cnt + 32'd1;
            if (hazard) stall_cnt  <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
